// File: rtl/wb_serial_pkg.sv
// wb_serial_pkg
// Shared definitions for the Wishbone <-> byte-stream bridge pair
// (wb_serial_bridge on the initiator side, serial_wb_master on the target
// side). The command byte encoding lives here so both ends agree on it.
//
// Contents:
//   CMD_READ / CMD_WRITE : first byte of every request packet
//   state_t              : transaction state of the bridge
//   addr_bytes()         : number of whole bytes needed to carry an address

package wb_serial_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_ACK
  } state_t;

  // ceil(addr_bits / 8)
  function automatic int addr_bytes(input int addr_bits);
    return (addr_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/wb_serial_bridge.sv
// wb_serial_bridge
// Wishbone pipelined slave that turns each bus cycle into a request packet on
// an 8-bit AXI-Stream output and completes it from the response packet on an
// 8-bit AXI-Stream input. One transaction is outstanding at a time.
//
// Request packet : command byte, address bytes (MSB first, zero padded),
//                  then data bytes (MSB first) for writes only.
// Response packet: BYTES data bytes (MSB first) for reads, one ignored byte
//                  for writes.
//
// Optional feature: define WB_SERIAL_BRIDGE_TIMEOUT_EN to add a response
// watchdog and the `timeout` output port.
//
// Ports:
//   clk, aresetn                 : clock, asynchronous active-low reset
//   s_wb_stb/we/addr/dat_m2s     : Wishbone request
//   s_wb_ack/stall/dat_s2m       : Wishbone completion, flow control, read data
//   axis_o_tvalid/tready/tdata/tlast : request byte stream (out)
//   axis_i_tvalid/tready/tdata       : response byte stream (in)
//   timeout                      : watchdog expiry pulse (macro builds only)

module wb_serial_bridge
  import wb_serial_pkg::*;
#(
  parameter int BYTES          = 2,
  parameter int ADDR_BITS      = 23,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_wb_stb,
  input  logic                   s_wb_we,
  input  logic [ADDR_BITS-1:0]   s_wb_addr,
  input  logic [BYTES*8-1:0]     s_wb_dat_m2s,
  output logic                   s_wb_ack,
  output logic                   s_wb_stall,
  output logic [BYTES*8-1:0]     s_wb_dat_s2m,
  input  logic                   axis_o_tready,
  output logic                   axis_o_tvalid,
  output logic [7:0]             axis_o_tdata,
  output logic                   axis_o_tlast,
  output logic                   axis_i_tready,
  input  logic                   axis_i_tvalid,
  input  logic [7:0]             axis_i_tdata
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  localparam int ADDR_BYTES = addr_bytes(ADDR_BITS);
  localparam int DATA_W     = BYTES * 8;
  localparam int APAD_W     = ADDR_BYTES * 8;
  localparam int PKT_MAX    = 1 + ADDR_BYTES + BYTES;
  localparam int SHR_W      = PKT_MAX * 8;
  localparam int CNT_W      = $clog2(PKT_MAX + 1);

  state_t            state;
  logic [SHR_W-1:0]  req_shr;
  logic              we_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [APAD_W-1:0] addr_pad;
  logic [CNT_W-1:0]  req_last_idx;
  logic [CNT_W-1:0]  rsp_last_idx;

`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  assign addr_pad     = APAD_W'(s_wb_addr);
  // Index of the final request byte / final response byte for the latched op
  assign req_last_idx = we_q ? CNT_W'(ADDR_BYTES + BYTES) : CNT_W'(ADDR_BYTES);
  assign rsp_last_idx = we_q ? '0 : CNT_W'(BYTES - 1);

  assign s_wb_stall   = (state != ST_IDLE);
  // The byte being offered is always the top byte of the packer
  assign axis_o_tdata = req_shr[SHR_W-1 -: 8];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      req_shr       <= '0;
      we_q          <= 1'b0;
      byte_cnt      <= '0;
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_i_tready <= 1'b0;
      s_wb_ack      <= 1'b0;
      s_wb_dat_s2m  <= '0;
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          s_wb_ack <= 1'b0;
          // stall is low here, so a strobe is an accept
          if (s_wb_stb) begin
            req_shr       <= {(s_wb_we ? CMD_WRITE : CMD_READ), addr_pad, s_wb_dat_m2s};
            we_q          <= s_wb_we;
            byte_cnt      <= '0;
            axis_o_tvalid <= 1'b1;
            axis_o_tlast  <= 1'b0;
            state         <= ST_SEND;
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end

        ST_SEND: begin
          if (axis_o_tvalid && axis_o_tready) begin
            if (byte_cnt == req_last_idx) begin
              axis_o_tvalid <= 1'b0;
              axis_o_tlast  <= 1'b0;
              byte_cnt      <= '0;
              axis_i_tready <= 1'b1;
              state         <= ST_RECV;
            end else begin
              req_shr      <= req_shr << 8;
              byte_cnt     <= byte_cnt + CNT_W'(1);
              axis_o_tlast <= ((byte_cnt + CNT_W'(1)) == req_last_idx);
            end
          end
        end

        ST_RECV: begin
          if (axis_i_tvalid) begin
            // Left shift, newest byte into the LSB: MSB-first reassembly
            s_wb_dat_s2m <= (s_wb_dat_s2m << 8) | DATA_W'(axis_i_tdata);
            if (byte_cnt == rsp_last_idx) begin
              axis_i_tready <= 1'b0;
              s_wb_ack      <= 1'b1;
              state         <= ST_ACK;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
          // A real completion in the same cycle takes priority over expiry
          if (!(axis_i_tvalid && (byte_cnt == rsp_last_idx))) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              axis_i_tready <= 1'b0;
              s_wb_ack      <= 1'b1;
              s_wb_dat_s2m  <= '1;
              timeout       <= 1'b1;
              state         <= ST_ACK;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
`endif
        end

        ST_ACK: begin
          s_wb_ack <= 1'b0;
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
          timeout  <= 1'b0;
`endif
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_bridge.sv
// tb_wb_serial_bridge
// Self-checking bench for wb_serial_bridge: a table of directed transactions,
// hand-written multi-cycle sequences (back-to-back reads, async reset, and the
// watchdog when WB_SERIAL_BRIDGE_TIMEOUT_EN is defined), then randomized
// transactions. Expected packets are produced by a byte-list model.

module tb_wb_serial_bridge;

  localparam int BYTES     = 2;
  localparam int ADDR_BITS = 23;
  localparam int AB        = (ADDR_BITS + 7) / 8;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        s_wb_stb;
  logic        s_wb_we;
  logic [22:0] s_wb_addr;
  logic [15:0] s_wb_dat_m2s;
  logic        s_wb_ack;
  logic        s_wb_stall;
  logic [15:0] s_wb_dat_s2m;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        i_tready;
  logic        i_tvalid;
  logic [7:0]  i_tdata;
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
  logic        timeout;
`endif

  wb_serial_bridge #(
    .BYTES(BYTES),
    .ADDR_BITS(ADDR_BITS),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .s_wb_stb(s_wb_stb),
    .s_wb_we(s_wb_we),
    .s_wb_addr(s_wb_addr),
    .s_wb_dat_m2s(s_wb_dat_m2s),
    .s_wb_ack(s_wb_ack),
    .s_wb_stall(s_wb_stall),
    .s_wb_dat_s2m(s_wb_dat_s2m),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_tdata(o_tdata),
    .axis_o_tlast(o_tlast),
    .axis_i_tready(i_tready),
    .axis_i_tvalid(i_tvalid),
    .axis_i_tdata(i_tdata)
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rsp_q[$];

  typedef struct {
    bit          we;
    logic [22:0] addr;
    logic [15:0] wdat;
    logic [15:0] rsp;
    int          pct;
    bit          early;
    int          exp_len;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: request packet and response packet as byte lists
  task automatic build_pkt(input bit we, input logic [22:0] addr,
                           input logic [15:0] wdat, input logic [15:0] rsp);
    logic [8*AB-1:0] apad;
    apad = {{(8*AB-ADDR_BITS){1'b0}}, addr};
    exp_q.delete();
    rsp_q.delete();
    exp_q.push_back(we ? 8'h01 : 8'h00);
    for (int i = AB - 1; i >= 0; i--) exp_q.push_back(apad[i*8 +: 8]);
    if (we) begin
      for (int i = BYTES - 1; i >= 0; i--) exp_q.push_back(wdat[i*8 +: 8]);
      rsp_q.push_back(rsp[7:0]);
    end else begin
      for (int i = BYTES - 1; i >= 0; i--) rsp_q.push_back(rsp[i*8 +: 8]);
    end
  endtask

  task automatic issue(input bit we, input logic [22:0] addr,
                       input logic [15:0] wdat, input bit hold);
    bit acc = 0;
    int guard = 0;
    s_wb_stb = 1'b1;
    s_wb_we = we;
    s_wb_addr = addr;
    s_wb_dat_m2s = wdat;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = !s_wb_stall;
      @(posedge clk); #1;
      guard++;
    end
    if (!hold) s_wb_stb = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic collect_req(input int pct, input int exp_len, input bit early);
    int n = 0;
    int guard = 0;
    bit done = 0;
    bit pend = 0;
    logic [7:0] held = 8'h00;
    logic [31:0] want;
    while (!done && guard < 300) begin
      guard++;
      o_tready = ($urandom_range(99) >= pct);
      @(negedge clk);
      chk("stall_busy", s_wb_stall, 1);
      if (early) chk("i_tready_early", i_tready, 0);
      if (pct == 0) chk("tvalid_cont", o_tvalid, 1);
      if (o_tvalid) begin
        if (pend) chk("tdata_stable", o_tdata, held);
        if (o_tready) begin
          want = (n < exp_q.size()) ? 32'(exp_q[n]) : 32'h100;
          chk("req_byte", o_tdata, want);
          chk("req_tlast", o_tlast, (n == exp_q.size() - 1));
          n++;
          pend = 0;
          if (o_tlast) done = 1;
        end else begin
          pend = 1;
          held = o_tdata;
        end
      end
      @(posedge clk); #1;
    end
    o_tready = 1'b0;
    chk("req_len", n, exp_len);
  endtask

  task automatic send_rsp(input int gap_pct);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < rsp_q.size() && guard < 500) begin
      if ($urandom_range(99) < gap_pct && guard > 0) i_tvalid = 1'b0;
      else begin
        i_tvalid = 1'b1;
        i_tdata = rsp_q[i];
      end
      @(negedge clk);
      if (guard == 0) begin
        chk("tvalid_after_last", o_tvalid, 0);
        chk("i_tready_recv", i_tready, 1);
      end
      hs = i_tvalid && i_tready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    i_tvalid = 1'b0;
    if (i < rsp_q.size()) chk("rsp_timeout", i, rsp_q.size());
  endtask

  task automatic check_ack(input bit we, input logic [15:0] exp_rd);
    @(negedge clk);
    chk("ack_pulse", s_wb_ack, 1);
    chk("stall_in_ack", s_wb_stall, 1);
    if (!we) chk("read_data", s_wb_dat_s2m, exp_rd);
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
    chk("no_timeout", timeout, 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_single", s_wb_ack, 0);
    chk("stall_idle", s_wb_stall, 0);
    if (!we) chk("read_hold", s_wb_dat_s2m, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input bit we, input logic [22:0] addr, input logic [15:0] wdat,
                         input logic [15:0] rsp, input int pct, input bit early,
                         input int exp_len);
    build_pkt(we, addr, wdat, rsp);
    if (early) begin
      i_tvalid = 1'b1;
      i_tdata = rsp_q[0];
    end
    issue(we, addr, wdat, 0);
    collect_req(pct, exp_len, early);
    send_rsp(pct / 2);
    check_ack(we, rsp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, s_wb_ack, 0);
    chk({tag, "_stall"}, s_wb_stall, 0);
    chk({tag, "_dat"}, s_wb_dat_s2m, 0);
    chk({tag, "_tvalid"}, o_tvalid, 0);
    chk({tag, "_tdata"}, o_tdata, 0);
    chk({tag, "_tlast"}, o_tlast, 0);
    chk({tag, "_itready"}, i_tready, 0);
`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
    chk({tag, "_timeout"}, timeout, 0);
`endif
  endtask

  initial begin
    tbl[0] = '{we: 1'b1, addr: 23'h012345, wdat: 16'hBEEF, rsp: 16'h0001, pct: 0,
               early: 1'b0, exp_len: 6, exp_rd: 16'h0000};
    tbl[1] = '{we: 1'b0, addr: 23'h7FFFFF, wdat: 16'h0000, rsp: 16'hCAFE, pct: 0,
               early: 1'b0, exp_len: 4, exp_rd: 16'hCAFE};
    tbl[2] = '{we: 1'b1, addr: 23'h012345, wdat: 16'hBEEF, rsp: 16'h00A5, pct: 50,
               early: 1'b0, exp_len: 6, exp_rd: 16'h0000};
    tbl[3] = '{we: 1'b0, addr: 23'h000001, wdat: 16'h0000, rsp: 16'h1234, pct: 30,
               early: 1'b1, exp_len: 4, exp_rd: 16'h1234};

    aresetn = 1'b0;
    s_wb_stb = 1'b0;
    s_wb_we = 1'b0;
    s_wb_addr = '0;
    s_wb_dat_m2s = '0;
    o_tready = 1'b0;
    i_tvalid = 1'b0;
    i_tdata = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Directed table
    for (int t = 0; t < 4; t++) begin
      run_txn(tbl[t].we, tbl[t].addr, tbl[t].wdat, tbl[t].rsp, tbl[t].pct,
              tbl[t].early, tbl[t].exp_len);
      if (!tbl[t].we) chk("table_rd", s_wb_dat_s2m, tbl[t].exp_rd);
    end

    // Back-to-back reads with stb held; request fields changed while stalled
    build_pkt(1'b0, 23'h055AA1, 16'h0, 16'h8001);
    issue(1'b0, 23'h055AA1, 16'h0, 1);
    s_wb_addr = 23'h00BEEF;
    s_wb_we = 1'b1;
    collect_req(0, 4, 0);
    send_rsp(0);
    @(negedge clk);
    chk("b2b_ack1", s_wb_ack, 1);
    chk("b2b_stall_ack", s_wb_stall, 1);
    chk("b2b_rd1", s_wb_dat_s2m, 16'h8001);
    @(posedge clk); #1;
    s_wb_we = 1'b0;
    @(negedge clk);
    chk("b2b_ack_low", s_wb_ack, 0);
    chk("b2b_stall_low", s_wb_stall, 0);
    @(posedge clk); #1;
    s_wb_stb = 1'b0;
    build_pkt(1'b0, 23'h00BEEF, 16'h0, 16'h7E3C);
    collect_req(0, 4, 0);
    send_rsp(0);
    check_ack(1'b0, 16'h7E3C);

    // Asynchronous reset in the middle of a request packet
    build_pkt(1'b1, 23'h001234, 16'h5678, 16'h0);
    issue(1'b1, 23'h001234, 16'h5678, 0);
    o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
    @(negedge clk);
    chk("pre_rst_tvalid", o_tvalid, 1);
    #1;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", s_wb_stall, 0);
    chk("post_rst_tvalid", o_tvalid, 0);
    @(posedge clk); #1;
    run_txn(1'b0, 23'h3C0F0F, 16'h0, 16'h4242, 0, 0, 4);

    // Randomized transactions
    for (int r = 0; r < 20; r++) begin
      bit          rwe;
      logic [22:0] raddr;
      logic [15:0] rdat;
      logic [15:0] rrsp;
      rwe   = $urandom_range(1);
      raddr = 23'($urandom);
      rdat  = 16'($urandom);
      rrsp  = 16'($urandom);
      run_txn(rwe, raddr, rdat, rrsp, $urandom_range(60), 1'($urandom_range(1)),
              1 + AB + (rwe ? BYTES : 0));
    end

`ifdef WB_SERIAL_BRIDGE_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 0;
      build_pkt(1'b0, 23'h000100, 16'h0, 16'h0);
      issue(1'b0, 23'h000100, 16'h0, 0);
      collect_req(0, 4, 0);
      while (!seen && n < 300) begin
        @(negedge clk);
        if (s_wb_ack) seen = 1;
        else begin
          @(posedge clk); #1;
          n++;
        end
      end
      chk("tmo_seen", seen, 1);
      chk("tmo_cycles", n, 100);
      chk("tmo_pulse", timeout, 1);
      chk("tmo_data", s_wb_dat_s2m, 16'hFFFF);
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_pulse_end", timeout, 0);
      chk("tmo_ack_end", s_wb_ack, 0);
      chk("tmo_idle", s_wb_stall, 0);
      @(posedge clk); #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_serial_bridge.md
# wb_serial_bridge

Wishbone pipelined slave that serialises each bus transaction into a byte-stream request packet on an AXI-Stream output and completes the transaction from the response packet on an AXI-Stream input. It is the initiator-side counterpart of `serial_wb_master` and speaks the identical packet format. Placing one bridge at each end of a UART link lets local Wishbone logic drive a remote Wishbone bus, for example SDRAM test traffic sourced from the FPGA itself.

## Interface
- `BYTES`, 2: Wishbone data width in bytes.
- `ADDR_BITS`, 23: Wishbone address width.
- `TIMEOUT_CYCLES`, 1000000: response watchdog limit. Used only with `WB_SERIAL_BRIDGE_TIMEOUT_EN`.

- `clk` in 1: single clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_wb_stb` in 1: request strobe.
- `s_wb_we` in 1: write enable.
- `s_wb_addr` in ADDR_BITS: address.
- `s_wb_dat_m2s` in BYTES*8: write data.
- `s_wb_ack` out 1: single-cycle completion pulse.
- `s_wb_stall` out 1: high whenever a request cannot be accepted.
- `s_wb_dat_s2m` out BYTES*8: read data, valid with `ack`.
- `axis_o_tready` in 1, `axis_o_tvalid` out 1, `axis_o_tdata` out 8, `axis_o_tlast` out 1: request stream.
- `axis_i_tready` out 1, `axis_i_tvalid` in 1, `axis_i_tdata` in 8: response stream.
- `timeout` out 1: one-cycle pulse on watchdog expiry. Present only with the macro.

## Operation
- `ADDR_BYTES` = ceil(ADDR_BITS/8).
- Request packet, in order:
  - Command byte: 0x01 for a write, 0x00 for a read.
  - `ADDR_BYTES` address bytes, MSB first, zero-padded above `ADDR_BITS`.
  - Writes only: `BYTES` data bytes, MSB first.
- `tlast` is asserted on the final byte of the request packet.
- Response packet:
  - Read: `BYTES` bytes, MSB first.
  - Write: one byte. Any value is accepted and then discarded.
- Only one transaction is outstanding at a time.
- `s_wb_stall` = (state != IDLE).
- A request is accepted when `stb && !stall`. At acceptance, `we`, `addr` and `dat_m2s` are latched into a shift register.
- States:
  - IDLE: on accept, go to SEND.
  - SEND: present the next byte; advance on `tvalid && tready`. After the last byte, go to RECV.
  - RECV: `axis_i_tready` = 1. Shift each byte into `dat_s2m` (left shift, new byte into the LSB). After the expected count, go to ACK.
  - ACK: `ack` = 1 for one cycle, then return to IDLE.
- Byte counter width is clog2 of (1 + ADDR_BYTES + BYTES + 1).
- `axis_i_tready` is 0 outside RECV. Response bytes arriving outside RECV are held off by backpressure and are never dropped.
- `axis_o_tvalid` stays high and `tdata` stays stable until the handshake completes.
- `dat_s2m` holds its last value between reads. After a write it is unspecified (the last shifted value).
- Reset values: `ack` 0, `stall` 0, `dat_s2m` 0, `axis_o_tvalid` 0, `tdata` 0, `tlast` 0, `axis_i_tready` 0, `timeout` 0; state IDLE.
- Reset asserted mid-packet abandons the transaction immediately. Neither stream is flushed; the link owner resynchronises.

## Timing
- Accept at edge N → first request byte valid from cycle N+1.
- With `tready` held high, one byte is sent per cycle.
- Last response byte handshaken at edge M → `ack` high during cycle M+1 → `stall` low from M+2.
- Minimum write latency, `stb` to `ack`: (1 + ADDR_BYTES + BYTES) + 1 + 1 cycles.
- `stb` held while `stall` is high is ignored; nothing is latched.
- `tready` deasserted on the last byte keeps `tvalid`/`tlast` asserted; the state does not advance.

## Configuration
- `WB_SERIAL_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on accept and increments in RECV.
  - On reaching `TIMEOUT_CYCLES` without completion: go to ACK with `dat_s2m` = all ones, pulse `timeout`, and return to IDLE.
  - Late response bytes are later consumed as part of the next response. This is documented misbehaviour; software resets the link.
- Undefined: no counter and no `timeout` port. RECV waits indefinitely.

## Structure
- Package `wb_serial_pkg` holds:
  - `CMD_READ`/`CMD_WRITE` byte constants.
  - A `state_t` enum.
  - A function `addr_bytes(ADDR_BITS)`.
- `serial_wb_master` imports the same package so the command encoding has one source.
- No sub-module. The packer shift register and the response accumulator are small enough to live inline.

## Test plan
- Write to addr 0x012345, data 0xBEEF, `tready`=1 → bytes 0x01,0x01,0x23,0x45,0xBE,0xEF; `tlast` on 0xEF. Inject response 0x01 → `ack` one cycle later.
- Read from addr 0x7FFFFF → bytes 0x00,0x7F,0xFF,0xFF. Inject response 0xCA,0xFE → `ack` with `dat_s2m`=0xCAFE.
- Random `tready` stalls during the write above → same byte sequence, no duplicates, `tdata` stable while stalled.
- `stb` asserted continuously for two back-to-back reads → second accepted only on the cycle after the first `ack`; `stall` high throughout the first transaction.
- Response bytes presented early, during SEND → `axis_i_tready`=0 until RECV; values correctly captured afterwards.
- Macro defined, `TIMEOUT_CYCLES`=100, no response → `timeout` and `ack` pulse 100 cycles after entering RECV, `dat_s2m`=0xFFFF. Separately, `aresetn` pulsed mid-SEND → all outputs return to reset values asynchronously.
